// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and default widths.
package alu_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int SHAMT_W_DEF    = 5;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_PASS_B = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WB    = 2'd2
  } state_t;

  // True for the three opcodes handled by the iterative shifter.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU: arithmetic, logic, compares and pass-through.
// Shift opcodes and undefined opcodes yield zero here; shifts are
// produced by the iterative shifter in the parent.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  logic w_lt_signed;
  logic w_lt_unsigned;

  assign w_lt_signed   = ($signed(i_a) < $signed(i_b));
  assign w_lt_unsigned = (i_a < i_b);

  // Opcode decode to the result value.
  always_comb begin
    o_result = {WIDTH{1'b0}};
    case (i_op)
      OP_ADD:    o_result = i_a + i_b;
      OP_SUB:    o_result = i_a - i_b;
      OP_AND:    o_result = i_a & i_b;
      OP_OR:     o_result = i_a | i_b;
      OP_XOR:    o_result = i_a ^ i_b;
      OP_SLT:    o_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
      OP_SLTU:   o_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
      OP_PASS_B: o_result = i_b;
      default:   o_result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_shift_exec.sv
// Execute stage between register-file read and write ports.
// IDLE accepts one op; ALU ops go straight to a one-cycle WB, shifts
// spend one cycle per bit in SHIFT before WB. Writes to register 0
// still spend the WB cycle but never raise wb_en.
module alu_shift_exec
  import alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SHAMT_W    = SHAMT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  wb_zero,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_op;
  logic [WIDTH-1:0]      r_shreg;
  logic [SHAMT_W-1:0]    r_count;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_reg;
  logic [WIDTH-1:0]      r_wb_data;
  logic                  r_wb_zero;
  logic                  r_in_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_in_shift;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [WIDTH-1:0]      w_alu_result;
  logic [WIDTH-1:0]      w_shift_step;
  logic                  w_load_wb;
  logic [WIDTH-1:0]      w_wb_data_nxt;
  logic [REG_ADDR_W-1:0] w_wb_reg_nxt;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_in_shift = is_shift_op(in_op);
  assign w_shamt    = in_b[SHAMT_W-1:0];

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_alu_result)
  );

  // One-bit step of the shift register in the captured op's direction.
  always_comb begin
    w_shift_step = r_shreg;
    case (r_op)
      OP_SLL:  w_shift_step = {r_shreg[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_step = {1'b0, r_shreg[WIDTH-1:1]};
      OP_SRA:  w_shift_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default: w_shift_step = r_shreg;
    endcase
  end

  // Next state and the writeback values loaded on entry to WB.
  always_comb begin
    w_next_state  = r_state;
    w_load_wb     = 1'b0;
    w_wb_data_nxt = r_wb_data;
    w_wb_reg_nxt  = r_wb_reg;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_shift && (w_shamt != {SHAMT_W{1'b0}})) begin
            w_next_state = S_SHIFT;
          end else begin
            w_next_state  = S_WB;
            w_load_wb     = 1'b1;
            w_wb_reg_nxt  = in_rd;
            w_wb_data_nxt = w_in_shift ? in_a : w_alu_result;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_count == SHAMT_W'(1)) begin
          w_next_state  = S_WB;
          w_load_wb     = 1'b1;
          w_wb_reg_nxt  = r_rd;
          w_wb_data_nxt = w_shift_step;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_WB: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register plus handshake/busy flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
      r_busy     <= (w_next_state != S_IDLE);
    end
  end

  // Operation capture at accept and the iterative shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= 4'd0;
      r_shreg <= {WIDTH{1'b0}};
      r_count <= {SHAMT_W{1'b0}};
      r_rd    <= {REG_ADDR_W{1'b0}};
    end else if (w_accept) begin
      r_op    <= in_op;
      r_shreg <= in_a;
      r_count <= w_shamt;
      r_rd    <= in_rd;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= w_shift_step;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

  // Writeback registers: strobe for exactly the WB cycle, data/reg held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en   <= 1'b0;
      r_wb_reg  <= {REG_ADDR_W{1'b0}};
      r_wb_data <= {WIDTH{1'b0}};
      r_wb_zero <= 1'b0;
    end else if (w_load_wb) begin
      r_wb_en   <= (w_wb_reg_nxt != {REG_ADDR_W{1'b0}});
      r_wb_reg  <= w_wb_reg_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_wb_zero <= (w_wb_data_nxt == {WIDTH{1'b0}});
    end else begin
      r_wb_en   <= 1'b0;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign wb_en    = r_wb_en;
  assign wb_reg   = r_wb_reg;
  assign wb_data  = r_wb_data;
  assign wb_zero  = r_wb_zero;

endmodule

// File: tb/tb_alu_shift_exec.sv
// Bench for alu_shift_exec: directed test-plan ops with literal results,
// then randomized traffic, all cross-checked every cycle against a
// behavioural model that counts busy cycles and computes results with
// plain SystemVerilog operators.
module tb_alu_shift_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_shift_exec dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_rd    (in_rd),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .wb_zero  (wb_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the opcode table.
  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] k;
    k = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << k;
      4'd8:    return a >> k;
      4'd9:    return 32'($signed(a) >>> k);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Number of busy cycles (SHIFT + WB) an accepted op occupies.
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && (b[4:0] != 5'd0))
      return int'(b[4:0]) + 1;
    else
      return 1;
  endfunction

  // Model state: cycles remaining until idle, pending result, visible WB values.
  int          m_rem = 0;
  logic [31:0] m_pend = 32'd0;
  logic [4:0]  m_pend_rd = 5'd0;
  logic [31:0] m_wb_data = 32'd0;
  logic [4:0]  m_wb_reg = 5'd0;
  logic        m_wb_zero = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem     <= 0;
      m_pend    <= 32'd0;
      m_pend_rd <= 5'd0;
      m_wb_data <= 32'd0;
      m_wb_reg  <= 5'd0;
      m_wb_zero <= 1'b0;
    end else if (m_rem == 0 && in_valid) begin
      m_rem     <= model_lat(in_op, in_b);
      m_pend    <= model_result(in_op, in_a, in_b);
      m_pend_rd <= in_rd;
      if (model_lat(in_op, in_b) == 1) begin
        m_wb_data <= model_result(in_op, in_a, in_b);
        m_wb_reg  <= in_rd;
        m_wb_zero <= (model_result(in_op, in_a, in_b) == 32'd0);
      end
    end else if (m_rem > 0) begin
      if (m_rem == 2) begin
        m_wb_data <= m_pend;
        m_wb_reg  <= m_pend_rd;
        m_wb_zero <= (m_pend == 32'd0);
      end
      m_rem <= m_rem - 1;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, (m_rem == 0)});
    check("busy",     {31'd0, busy},     {31'd0, (m_rem != 0)});
    check("wb_en",    {31'd0, wb_en},    {31'd0, (m_rem == 1) && (m_wb_reg != 5'd0)});
    check("wb_reg",   {27'd0, wb_reg},   {27'd0, m_wb_reg});
    check("wb_data",  wb_data,           m_wb_data);
    if (m_rem == 1)
      check("wb_zero", {31'd0, wb_zero}, {31'd0, m_wb_zero});
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Issue one op, scramble inputs after accept, then check the WB cycle against literals.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat);
    int cnt;
    wait_idle();
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
    cnt = 1;
    while (!wb_en && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_lat"},   cnt, exp_lat);
    check({name, "_wben"},  {31'd0, wb_en}, 32'd1);
    check({name, "_data"},  wb_data, exp_data);
    check({name, "_reg"},   {27'd0, wb_reg}, {27'd0, rd});
    check({name, "_zero"},  {31'd0, wb_zero}, {31'd0, (exp_data == 32'd0)});
    check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    // Pin the model itself with hand-computed values.
    check("model_sra",  model_result(4'd9, 32'h8000_0000, 32'd4), 32'hF800_0000);
    check("model_slt",  model_result(4'd5, 32'hFFFF_FFFF, 32'd1), 32'd1);
    check("model_sltu", model_result(4'd6, 32'hFFFF_FFFF, 32'd1), 32'd0);
    check("model_lat",  model_lat(4'd7, 32'hFFFF_FFFF), 32);

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wben",  {31'd0, wb_en}, 32'd0);
    check("rst_zero",  {31'd0, wb_zero}, 32'd0);
    #2 reset = 1'b0;

    run_op("add",  4'd0,  32'h0000_0005, 32'h0000_0007, 5'd3, 32'h0000_000C, 1);
    run_op("sub",  4'd1,  32'h0000_0000, 32'h0000_0001, 5'd4, 32'hFFFF_FFFF, 1);
    run_op("slt",  4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 32'h0000_0001, 1);
    run_op("sltu", 4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 5'd7, 32'h0000_0000, 1);
    run_op("sra",  4'd9,  32'h8000_0000, 32'h0000_0004, 5'd5, 32'hF800_0000, 5);
    run_op("srl",  4'd8,  32'h8000_0000, 32'h0000_0004, 5'd5, 32'h0800_0000, 5);
    run_op("sll",  4'd7,  32'h0000_0001, 32'h0000_001F, 5'd8, 32'h8000_0000, 32);
    run_op("sh0",  4'd8,  32'h1234_5678, 32'hFFFF_FFE0, 5'd9, 32'h1234_5678, 1);
    run_op("und",  4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 5'd10, 32'h0000_0000, 1);

    // XOR to r0: WB cycle spent with no strobe.
    wait_idle();
    in_valid = 1'b1; in_op = 4'd4; in_a = 32'hFFFF_0000; in_b = 32'h0F0F_0F0F; in_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("r0_wben",  {31'd0, wb_en}, 32'd0);
    check("r0_busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("r0_ready", {31'd0, in_ready}, 32'd1);

    // Reset during a long shift discards it.
    wait_idle();
    in_valid = 1'b1; in_op = 4'd7; in_a = 32'h0000_0001; in_b = 32'd20; in_rd = 5'd11;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_ready", {31'd0, in_ready}, 32'd1);
    check("mid_busy",  {31'd0, busy}, 32'd0);
    check("mid_wben",  {31'd0, wb_en}, 32'd0);
    check("mid_reg",   {27'd0, wb_reg}, 32'd0);
    check("mid_data",  wb_data, 32'd0);
    check("mid_zero",  {31'd0, wb_zero}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    run_op("post", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd12, 32'h8000_0000, 1);

    // Randomized traffic with inputs changing every cycle and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 4'($urandom_range(0, 15));
      in_a     = $urandom;
      in_b     = ($urandom_range(0, 1) != 0) ? $urandom : {27'($urandom), 5'($urandom_range(0, 6))};
      in_rd    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift_exec.md
Name: alu_shift_exec

Overview:
- Execute stage directly downstream of the register file's read ports and upstream of its write port.
- Accepts one operation with two operands (from read_data1/read_data2) and a destination register over a valid/ready handshake.
- Computes single-cycle ALU ops, or a shift via an iterative 1-bit-per-cycle shifter.
- Delivers a one-cycle writeback (wb_en/wb_reg/wb_data) that drives reg_write/write_reg/write_data.

Parameters:
- WIDTH, 32, operand/result width.
- REG_ADDR_W, 5, destination register index width.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept; high only in IDLE.
- in_op  input  4  opcode (see Behaviour).
- in_a  input  WIDTH  operand A (read_data1).
- in_b  input  WIDTH  operand B (read_data2); shifts use in_b[SHAMT_W-1:0].
- in_rd  input  REG_ADDR_W  destination register.
- wb_en  output  1  one-cycle write strobe to the register file.
- wb_reg  output  REG_ADDR_W  write address.
- wb_data  output  WIDTH  write data.
- wb_zero  output  1  wb_data == 0; valid in the WB cycle.
- busy  output  1  high in SHIFT or WB.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, in_ready=1, wb_en=0, wb_reg=0, wb_data=0, wb_zero=0, busy=0, internal count=0.
- Handshake:
  - Accept occurs on a rising edge with in_valid && in_ready.
  - in_op, in_a, in_b and in_rd are captured at accept; later input changes are ignored.
  - in_valid while not ready is held off with no effect.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed compare), 6 SLTU (unsigned compare); both produce 1 or 0, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA (arithmetic, sign-fill).
  - 10 PASS_B.
  - 11-15 are undefined and produce result 0, which is still written back.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- State IDLE: in_ready=1.
  - Non-shift op accepted at edge N: result registered, go to WB; wb_en is high during cycle N+1.
  - Shift op accepted with shamt k: shift register loaded with in_a.
    - k=0: go to WB; wb_data=in_a at N+1.
    - k>0: go to SHIFT with count=k.
- State SHIFT: each cycle shifts the register by one bit in the op's direction and decrements count.
  - Leaving the cycle with count==1 goes to WB, so wb_en is high at cycle N+k+1.
  - SRA replicates the MSB on every step.
- State WB (exactly one cycle): wb_data/wb_reg/wb_zero present.
  - wb_en=1 unless wb_reg==0; writes to register 0 are suppressed with wb_en=0, but the state is still spent.
  - Next state is IDLE.
- Outputs outside WB: wb_en=0; wb_data and wb_reg hold their last values.
- Throughput:
  - Non-shift: one op per 2 cycles.
  - Shift: one op per k+2 cycles, or 2 cycles when k=0.
- Reset mid-operation (SHIFT or WB): the in-flight op is discarded with no wb_en pulse; the block returns to IDLE with reset values.
- A back-to-back in_valid held high is accepted on the first IDLE cycle after WB.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_PASS_B);
  - state encoding (S_IDLE, S_SHIFT, S_WB);
  - WIDTH/SHAMT_W defaults.
- One natural sub-module, alu_comb: purely combinational, covering ops 0-6 and 10. The FSM, iterative shifter and writeback registers live in alu_shift_exec.

Test Plan:
- Reset, then ADD a=0x0000_0005, b=0x0000_0007, rd=3 → wb_en=1 exactly one cycle later, wb_reg=3, wb_data=0x0000_000C, wb_zero=0; in_ready low during WB.
- SUB a=0, b=1, rd=4 → wb_data=0xFFFF_FFFF. SLT a=0xFFFF_FFFF, b=1 → 1. SLTU with the same operands → 0 and wb_zero=1.
- SRA a=0x8000_0000, b=4, rd=5 → busy for 5 cycles, wb_en at accept+5, wb_data=0xF800_0000.
- SRL with the same a and b → 0x0800_0000. SLL a=1, b=31 → 0x8000_0000 at accept+32.
- Shift with b=0 → wb_data=a at accept+1.
- XOR rd=0 → no wb_en pulse; in_ready returns 1 after 2 cycles.
- Undefined op 13 → wb_data=0 with wb_en=1.
- Accept SLL with b=20, assert reset at accept+6 → no wb_en ever pulses; all outputs at reset values.
- A following ADD is accepted normally after reset release.
